// File: rtl/i2sout_if.sv
// i2sout_if: sample-side ready/valid handshake plus the serial I2S outputs
// of the i2sout transmitter, bundled so benches and parents connect one port.
// The master modport is the sample producer; the slave modport is i2sout.
interface i2sout_if #(
  parameter int BITS_PRECISION = 24
);

  logic [BITS_PRECISION-1:0] in_left;
  logic [BITS_PRECISION-1:0] in_right;
  logic                      in_valid;
  logic                      in_ready;
  logic                      ws;
  logic                      sd;
  logic                      frame_start;
  logic                      underflow;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready,
    input  ws,
    input  sd,
    input  frame_start,
    input  underflow
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready,
    output ws,
    output sd,
    output frame_start,
    output underflow
  );

endinterface

// File: rtl/i2sout.sv
// i2sout: Philips I2S transmitter clocked by sck.
// A ready/valid sample pair enters a one-deep holding buffer and is moved
// into a 2*BITS_PRECISION shift register at the load edge (the posedge that
// ends frame slot k=0). ws low = left, high = right, MSB first, sd lags the
// ws edge by one sck.
// Optional feature: define I2SOUT_UNDERFLOW_HOLD_EN to repeat the last
// transmitted pair on underflow; by default an underflow frame is silence.
module i2sout #(
  parameter int BITS_PRECISION = 24
) (
  input  logic     sck,
  input  logic     rst,
  i2sout_if.slave  bus
);

  localparam int N  = BITS_PRECISION;
  localparam int W  = 2 * N;
  localparam int KW = $clog2(W);

  localparam logic [KW-1:0] K_ZERO = '0;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_HALF = KW'(N);
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  // frame slot counter and registered serial outputs
  logic [KW-1:0]  k_q, k_d;
  logic           ws_q, ws_d;
  logic           sd_q, sd_d;
  logic [W-1:0]   shift_q, shift_d;

  // one-deep holding buffer between the handshake and the shift register
  logic [N-1:0]   buf_l_q, buf_l_d;
  logic [N-1:0]   buf_r_q, buf_r_d;
  logic           buf_full_q, buf_full_d;

  // status pulses, both aligned to slot k=1
  logic           frame_start_q, frame_start_d;
  logic           underflow_q, underflow_d;

`ifdef I2SOUT_UNDERFLOW_HOLD_EN
  // last pair moved into the shift register, replayed on underflow
  logic [W-1:0]   last_q, last_d;
`endif

  // decoded events of the current cycle
  logic           load_edge;
  logic           accept;
  logic [W-1:0]   load_val;

  // slot counter wraps every frame; ws is precomputed from the next slot so it is a flop
  always_comb begin
    k_d = (k_q == K_LAST) ? K_ZERO : k_q + K_ONE;
    ws_d = (k_d >= K_HALF);
  end

  // buffer handshake, load-edge selection and MSB-first shifting
  always_comb begin
    load_edge     = (k_q == K_ZERO);
    accept        = bus.in_valid && !buf_full_q;
    load_val      = '0;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    buf_full_d    = buf_full_q;
    shift_d       = {shift_q[W-2:0], 1'b0};
    sd_d          = shift_q[W-1];
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;
`ifdef I2SOUT_UNDERFLOW_HOLD_EN
    last_d        = last_q;
`endif

    if (load_edge) begin
      frame_start_d = 1'b1;
      if (buf_full_q) begin
        load_val   = {buf_l_q, buf_r_q};
        buf_full_d = 1'b0;
      end else if (bus.in_valid) begin
        load_val = {bus.in_left, bus.in_right};
      end else begin
        underflow_d = 1'b1;
`ifdef I2SOUT_UNDERFLOW_HOLD_EN
        load_val = last_q;
`else
        load_val = '0;
`endif
      end
      // the MSB goes straight to sd so it appears at k=1; the rest stays queued
      sd_d    = load_val[W-1];
      shift_d = {load_val[W-2:0], 1'b0};
`ifdef I2SOUT_UNDERFLOW_HOLD_EN
      last_d  = load_val;
`endif
    end else if (accept) begin
      buf_l_d    = bus.in_left;
      buf_r_d    = bus.in_right;
      buf_full_d = 1'b1;
    end
  end

  // state register with synchronous reset; reset mid-frame drops any buffered pair
  always_ff @(posedge sck) begin
    if (rst) begin
      k_q           <= '0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      shift_q       <= '0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      buf_full_q    <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
`ifdef I2SOUT_UNDERFLOW_HOLD_EN
      last_q        <= '0;
`endif
    end else begin
      k_q           <= k_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      shift_q       <= shift_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      buf_full_q    <= buf_full_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
`ifdef I2SOUT_UNDERFLOW_HOLD_EN
      last_q        <= last_d;
`endif
    end
  end

  assign bus.in_ready    = !buf_full_q;
  assign bus.ws          = ws_q;
  assign bus.sd          = sd_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underflow   = underflow_q;

endmodule
